seq_multiplier: RTL and testbench

Parametrised sequential multiplier with an integrated controller and a start/done handshake. It multiplies two WIDTH-bit operands one DIGIT-bit digit of `b` per cycle, MSB digit first, using a shift-left-and-add accumulator. It supports both unsigned and two's-complement signed operation. It replaces the fixed 4×4, externally sequenced multiplier datapath and is a drop-in arithmetic unit for any block needing a compact multiplier.

---
 rtl/mult_pkg.sv | 15 +
 rtl/digit_multiplier.sv | 22 ++
 rtl/seq_multiplier.sv | 91 +++++++++
 tb/tb_seq_multiplier.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: controller state encoding
// and the digit-step count helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } state_t;

   function automatic int digit_steps(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/digit_multiplier.sv
// Combinational WIDTH x DIGIT unsigned multiplier producing one partial product
// per cycle for the sequential multiplier.
module digit_multiplier #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic [WIDTH-1:0]       a,
   input  logic [DIGIT-1:0]       digit,
   output logic [WIDTH+DIGIT-1:0] partial
);

   // Shift-and-add over the few bits of the digit; DIGIT is at most 4.
   always_comb begin
      partial = '0;
      for (int i = 0; i < DIGIT; i++) begin
         if (digit[i]) begin
            partial = partial + ((WIDTH+DIGIT)'(a) << i);
         end
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier consuming DIGIT bits of b per cycle,
// MSB digit first, with a start/busy/done handshake.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int N     = digit_steps(WIDTH, DIGIT);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t               state;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic                 neg;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH+DIGIT-1:0] partial;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;

   // The most negative operand's magnitude still fits in WIDTH unsigned bits.
   assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign busy  = (state != IDLE);

   digit_multiplier #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) u_digit_multiplier (
      .a       (a_reg),
      .digit   (b_reg[WIDTH-1 -: DIGIT]),
      .partial (partial)
   );

   // b_reg shifts left each step so its top digit is always the next one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a_mag;
                  b_reg <= b_mag;
                  neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= (acc << DIGIT) + (2*WIDTH)'(partial);
               b_reg <= b_reg << DIGIT;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N-1)) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               product <= neg ? -acc : acc;
               done    <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: default instance plus three other
// WIDTH/DIGIT configurations checked against a reference product model.
module tb_seq_multiplier;

   logic        clk;
   logic        rst;
   logic        start0, start1, start2, start3;
   logic        sm0, sm1, sm2, sm3;
   logic [7:0]  a0, b0, a1, b1, a2, b2;
   logic [15:0] a3, b3;
   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic [15:0] p0, p1, p2;
   logic [31:0] p3;

   int checks;
   int errors;

   seq_multiplier #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .product(p0)
   );

   seq_multiplier #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
      .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .product(p1)
   );

   seq_multiplier #(.WIDTH(8), .DIGIT(4)) u_dut_d4 (
      .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .product(p2)
   );

   seq_multiplier #(.WIDTH(16), .DIGIT(4)) u_dut_w16 (
      .clk(clk), .rst(rst), .start(start3), .signed_mode(sm3),
      .a(a3), .b(b3), .busy(busy3), .done(done3), .product(p3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int width_of(input int sel);
      return (sel == 3) ? 16 : 8;
   endfunction

   function automatic int latency_of(input int sel);
      case (sel)
         0:       return 5;
         1:       return 9;
         2:       return 3;
         default: return 5;
      endcase
   endfunction

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return done0;
         1:       return done1;
         2:       return done2;
         default: return done3;
      endcase
   endfunction

   function automatic logic [31:0] prod_of(input int sel);
      case (sel)
         0:       return {16'h0, p0};
         1:       return {16'h0, p1};
         2:       return {16'h0, p2};
         default: return p3;
      endcase
   endfunction

   // Reference product: plain integer multiply of the interpreted operands.
   function automatic logic [31:0] ref_mul(input int w, input bit sm,
                                           input logic [15:0] av, input logic [15:0] bv);
      longint sa;
      longint sb;
      longint pr;
      longint mask;
      mask = (longint'(1) << w) - 1;
      sa = longint'(av) & mask;
      sb = longint'(bv) & mask;
      if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
      if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
      pr = (sa * sb) & ((longint'(1) << (2*w)) - 1);
      return 32'(pr);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise start for exactly one edge; returns #1 after that start edge.
   task automatic apply_stimulus(input int sel, input bit sm,
                                 input logic [15:0] av, input logic [15:0] bv);
      case (sel)
         0:       begin start0 = 1'b1; sm0 = sm; a0 = av[7:0]; b0 = bv[7:0]; end
         1:       begin start1 = 1'b1; sm1 = sm; a1 = av[7:0]; b1 = bv[7:0]; end
         2:       begin start2 = 1'b1; sm2 = sm; a2 = av[7:0]; b2 = bv[7:0]; end
         default: begin start3 = 1'b1; sm3 = sm; a3 = av;      b3 = bv;      end
      endcase
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_result(input int sel, output int lat, output logic [31:0] prod);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done_of(sel) && lat < 40);
      if (!done_of(sel)) lat = -1;
      prod = prod_of(sel);
   endtask

   task automatic run_check(input int sel, input bit sm, input logic [15:0] av,
                            input logic [15:0] bv, input logic [31:0] exp, input string tag);
      int          lat;
      logic [31:0] prod;
      apply_stimulus(sel, sm, av, bv);
      wait_result(sel, lat, prod);
      check_output({tag, "_latency"}, 32'(lat), 32'(latency_of(sel)));
      check_output({tag, "_product"}, prod, exp);
   endtask

   initial begin
      int          lat;
      int          n_done;
      int          gaps;
      logic [31:0] cap;
      logic [15:0] rav;
      logic [15:0] rbv;
      bit          rsm;

      checks = 0;
      errors = 0;
      rst = 1'b0;
      {start0, start1, start2, start3} = '0;
      {sm0, sm1, sm2, sm3} = '0;
      {a0, b0, a1, b1, a2, b2} = '0;
      {a3, b3} = '0;

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_busy", {31'h0, busy0}, 32'h0);
      check_output("reset_done", {31'h0, done0}, 32'h0);
      check_output("reset_product", {16'h0, p0}, 32'h0);
      check_output("reset_product_w16", p3, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] default configuration directed vectors");
      run_check(0, 1'b0, 16'd200, 16'd150, 32'h7530, "u_200x150");
      check_output("busy_at_done", {31'h0, busy0}, 32'h0);
      @(posedge clk);
      #1;
      check_output("done_single_pulse", {31'h0, done0}, 32'h0);
      check_output("product_held", {16'h0, p0}, 32'h7530);
      run_check(0, 1'b1, 16'h00FD, 16'h0005, 32'hFFF1, "s_m3x5");
      run_check(0, 1'b1, 16'h0080, 16'h0080, 32'h4000, "s_min_x_min");
      run_check(0, 1'b1, 16'h007F, 16'h0080, 32'hC080, "s_max_x_min");

      $display("[TB] start and operand changes while busy");
      apply_stimulus(0, 1'b0, 16'h0012, 16'h0034);
      start0 = 1'b1;
      sm0 = 1'b1;
      a0 = 8'hFF;
      b0 = 8'hFF;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      a0 = 8'h55;
      n_done = 0;
      cap = '0;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         #1;
         if (done0) begin
            n_done++;
            cap = {16'h0, p0};
         end
      end
      check_output("ignored_start_done_count", 32'(n_done), 32'd1);
      check_output("ignored_start_product", cap, 32'h03A8);
      check_output("ignored_start_idle", {31'h0, busy0}, 32'h0);

      $display("[TB] back-to-back operations");
      apply_stimulus(0, 1'b0, 16'd0, 16'd255);
      wait_result(0, lat, cap);
      check_output("b2b_first_latency", 32'(lat), 32'd5);
      check_output("b2b_first_product", cap, 32'h0);
      apply_stimulus(0, 1'b0, 16'd7, 16'd9);
      gaps = 0;
      lat = 0;
      do begin
         if (!busy0) gaps++;
         @(posedge clk);
         #1;
         lat++;
      end while (!done0 && lat < 40);
      check_output("b2b_busy_gaps", 32'(gaps), 32'd0);
      check_output("b2b_second_latency", 32'(lat), 32'd5);
      check_output("b2b_second_product", {16'h0, p0}, 32'h003F);

      $display("[TB] reset in the middle of an operation");
      apply_stimulus(0, 1'b0, 16'd100, 16'd100);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("midrst_busy", {31'h0, busy0}, 32'h0);
      check_output("midrst_product", {16'h0, p0}, 32'h0);
      check_output("midrst_done", {31'h0, done0}, 32'h0);
      rst = 1'b1;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done0) n_done++;
      end
      check_output("midrst_no_done", 32'(n_done), 32'd0);
      run_check(0, 1'b0, 16'd15, 16'd15, 32'h00E1, "u_15x15");

      rst = 1'b0;
      start0 = 1'b1;
      a0 = 8'd3;
      b0 = 8'd3;
      @(posedge clk);
      #1;
      check_output("reset_over_start", {31'h0, busy0}, 32'h0);
      rst = 1'b1;
      start0 = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] other WIDTH/DIGIT configurations");
      run_check(1, 1'b1, 16'h0081, 16'h0002, 32'hFF02, "d1_s_m127x2");
      run_check(1, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, "d1_u_255x255");
      run_check(2, 1'b0, 16'd200, 16'd150, 32'h7530, "d4_u_200x150");
      run_check(2, 1'b1, 16'h00FD, 16'h0005, 32'hFFF1, "d4_s_m3x5");
      run_check(3, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "w16_s_min_x_max");
      run_check(3, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_u_max_x_max");

      $display("[TB] random operands against reference model");
      for (int sel = 0; sel < 4; sel++) begin
         for (int i = 0; i < 6; i++) begin
            rav = 16'($urandom);
            rbv = 16'($urandom);
            rsm = 1'($urandom_range(0, 1));
            run_check(sel, rsm, rav, rbv, ref_mul(width_of(sel), rsm, rav, rbv),
                      $sformatf("rand_sel%0d_%0d_sm%0d_%0h_%0h", sel, i, rsm, rav, rbv));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
